// File: rtl/inst_buffer.sv
// Instruction buffer: circular queue between fetch and decode, up to `N in / `N out per cycle.
// Latency: one cycle from enqueue edge to out_packet; no combinational in-to-out path.
// Backpressure: ready drops when fewer than `N free slots remain; dequeue is clipped to count.
//
// Ports:
//   clock, reset (async active-low), squash (flush everything)
//   in_packet[`N]   fetch group, valid lanes contiguous from lane 0
//   dequeue_num     how many instructions decode takes this cycle (0..`N)
//   ready           fetch may present a group this cycle
//   out_packet[`N]  oldest buffered instructions, lane 0 oldest
//   count           instructions currently held

`ifndef N
`define N 3
`endif

// Fetch/decode pipeline register contents shared by fetch, this buffer and decode.
package sys_defs_pkg;
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] PC;
        logic [31:0] NPC;
        logic        predict_taken;
        logic [31:0] predict_target;
        logic        valid;
    } IF_ID_PACKET;
endpackage

module inst_buffer
    import sys_defs_pkg::*;
#(
    parameter int SIZE = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         squash,
    input  IF_ID_PACKET [`N-1:0]         in_packet,
    input  logic [$clog2(`N+1)-1:0]      dequeue_num,
    output logic                         ready,
    output IF_ID_PACKET [`N-1:0]         out_packet,
    output logic [$clog2(SIZE+1)-1:0]    count
);

    localparam int PW = $clog2(SIZE);
    localparam int CW = $clog2(SIZE+1);
    localparam int DW = $clog2(`N+1);

    IF_ID_PACKET    r_mem [SIZE];
    logic [PW-1:0]  r_head;
    logic [PW-1:0]  r_tail;
    logic [CW-1:0]  r_count;

    logic [DW-1:0]  w_enq_num;
    logic [DW-1:0]  w_deq_num;

    assign count = r_count;
    // Depends on registered count only, so a same-cycle dequeue cannot open the gate.
    assign ready = (r_count <= CW'(SIZE - `N));

    always_comb begin
        w_enq_num = '0;
        if (ready && !squash) begin
            for (int i = 0; i < `N; i++) begin
                w_enq_num = w_enq_num + DW'(in_packet[i].valid);
            end
        end
        w_deq_num = '0;
        if (!squash) begin
            if (CW'(dequeue_num) < r_count) begin
                w_deq_num = dequeue_num;
            end else begin
                w_deq_num = DW'(r_count);
            end
        end
    end

    // SIZE is a power of two, so PW-bit pointer addition wraps modulo SIZE for free.
    always_comb begin
        for (int i = 0; i < `N; i++) begin
            out_packet[i]       = r_mem[r_head + PW'(i)];
            out_packet[i].valid = (CW'(i) < r_count) && !squash;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int j = 0; j < SIZE; j++) begin
                r_mem[j] <= '0;
            end
        end else if (squash) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < `N; i++) begin
                if (DW'(i) < w_enq_num) begin
                    r_mem[r_tail + PW'(i)] <= in_packet[i];
                end
            end
            r_head  <= r_head + PW'(w_deq_num);
            r_tail  <= r_tail + PW'(w_enq_num);
            r_count <= r_count + CW'(w_enq_num) - CW'(w_deq_num);
        end
    end

endmodule

// File: tb/tb_inst_buffer.sv
// Bench for inst_buffer with N=3, SIZE=8: directed vector table plus wrap, squash and async-reset sequences.
// Inputs driven on the falling edge; outputs sampled 1 time unit after either edge.
// Expected values are hand-computed constants or a simple sequential-PC model.

`ifndef N
`define N 3
`endif

module tb_inst_buffer;
    import sys_defs_pkg::*;

    logic                clock;
    logic                reset;
    logic                squash;
    IF_ID_PACKET [2:0]   in_packet;
    logic [1:0]          dequeue_num;
    logic                ready;
    IF_ID_PACKET [2:0]   out_packet;
    logic [3:0]          count;

    int checks = 0;
    int errors = 0;

    inst_buffer #(.SIZE(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .squash      (squash),
        .in_packet   (in_packet),
        .dequeue_num (dequeue_num),
        .ready       (ready),
        .out_packet  (out_packet),
        .count       (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic sq;      // squash
        int   nv_in;   // valid lanes presented
        int   pc_in;   // PC of lane 0 (lanes step by 4)
        int   deq;     // dequeue_num
        int   pre_nv;  // valid out lanes before the edge
        int   cnt;     // count after the edge
        logic rdy;     // ready after the edge
        int   nv_out;  // valid out lanes after the edge
        int   pc0;     // PC of out lane 0 after the edge
    } vec_t;

    vec_t vt [14];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic sq, input int nv, input int pc, input int deq);
        squash      = sq;
        dequeue_num = 2'(deq);
        for (int i = 0; i < 3; i++) begin
            in_packet[i].valid          = (i < nv);
            in_packet[i].PC             = 32'(pc + 4*i);
            in_packet[i].NPC            = 32'(pc + 4*i + 4);
            in_packet[i].inst           = 32'(pc + 4*i) ^ 32'hA5A5_0000;
            in_packet[i].predict_taken  = 1'b0;
            in_packet[i].predict_target = 32'h0;
        end
    endtask

    function automatic int nv_out_now();
        int n = 0;
        for (int i = 0; i < 3; i++) n += int'(out_packet[i].valid);
        return n;
    endfunction

    task automatic chk_lanes(input string name, input int nv, input int pc0);
        chk({name, " nvalid"}, nv_out_now(), nv);
        for (int i = 0; i < nv; i++) begin
            chk({name, " pc"}, int'(out_packet[i].PC), pc0 + 4*i);
            chk({name, " inst"}, int'(out_packet[i].inst), int'(32'(pc0 + 4*i) ^ 32'hA5A5_0000));
        end
    endtask

    // Occupancy bound, checked every cycle.
    always @(negedge clock) begin
        if (reset) chk("count bound", int'(count > 4'd8), 0);
    end

    // Protocol: valid lanes must be contiguous from lane 0.
    always @(posedge clock) begin
        assert (!(in_packet[1].valid && !in_packet[0].valid) &&
                !(in_packet[2].valid && !in_packet[1].valid))
            else $error("protocol: non-contiguous in_packet valid pattern");
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //        sq  nvi pc   deq pre cnt rdy nvo pc0
        vt[0]  = '{0, 3, 0,   0,  0,  3,  1,  3,  0};
        vt[1]  = '{0, 3, 12,  0,  3,  6,  0,  3,  0};
        vt[2]  = '{0, 3, 24,  0,  3,  6,  0,  3,  0};
        vt[3]  = '{0, 3, 24,  3,  3,  3,  1,  3,  12};
        vt[4]  = '{0, 0, 0,   1,  3,  2,  1,  2,  16};
        vt[5]  = '{0, 3, 24,  3,  2,  3,  1,  3,  24};
        vt[6]  = '{0, 2, 36,  0,  3,  5,  1,  3,  24};
        vt[7]  = '{0, 3, 44,  0,  3,  8,  0,  3,  24};
        vt[8]  = '{0, 0, 0,   3,  3,  5,  1,  3,  36};
        vt[9]  = '{1, 3, 60,  0,  0,  0,  1,  0,  0};
        vt[10] = '{0, 3, 100, 0,  0,  3,  1,  3,  100};
        vt[11] = '{0, 1, 112, 2,  3,  2,  1,  2,  108};
        vt[12] = '{0, 0, 0,   3,  2,  0,  1,  0,  0};
        vt[13] = '{0, 3, 200, 3,  0,  3,  1,  3,  200};

        reset = 1'b0;
        drive(1'b0, 0, 0, 0);
        #1;
        chk("reset count", int'(count), 0);
        chk("reset ready", int'(ready), 1);
        chk("reset nvalid", nv_out_now(), 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        for (int v = 0; v < 14; v++) begin
            drive(vt[v].sq, vt[v].nv_in, vt[v].pc_in, vt[v].deq);
            #1;
            chk($sformatf("v%0d pre nvalid", v), nv_out_now(), vt[v].pre_nv);
            @(posedge clock);
            #1;
            chk($sformatf("v%0d count", v), int'(count), vt[v].cnt);
            chk($sformatf("v%0d ready", v), int'(ready), int'(vt[v].rdy));
            chk_lanes($sformatf("v%0d", v), vt[v].nv_out, vt[v].pc0);
            @(negedge clock);
        end

        // Steady stream: 3 in / 3 out for 20 cycles, pointers wrap repeatedly.
        for (int k = 0; k < 20; k++) begin
            drive(1'b0, 3, 212 + 12*k, 3);
            @(posedge clock);
            #1;
            chk($sformatf("wrap%0d count", k), int'(count), 3);
            chk_lanes($sformatf("wrap%0d", k), 3, 212 + 12*k);
            @(negedge clock);
        end

        // Bring count to 4, then assert reset between edges.
        drive(1'b0, 1, 500, 0);
        @(posedge clock);
        #1;
        chk("pre-reset count", int'(count), 4);
        @(negedge clock);
        drive(1'b0, 0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        chk("async reset count", int'(count), 0);
        chk("async reset nvalid", nv_out_now(), 0);
        chk("async reset ready", int'(ready), 1);
        @(posedge clock);
        #1;
        chk("held reset count", int'(count), 0);
        @(negedge clock);
        reset = 1'b1;
        drive(1'b0, 3, 600, 0);
        @(posedge clock);
        #1;
        chk("post-reset count", int'(count), 3);
        chk_lanes("post-reset", 3, 600);
        @(negedge clock);
        drive(1'b0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_buffer.md
INST_BUFFER -- requirements
Module: inst_buffer

Interface
REQ-001 SHALL have parameter SIZE, default 16, buffer depth in instructions; power of 2, at least 2*`N.
REQ-002 SHALL take `N from sys_defs.svh as the per-cycle enqueue/dequeue width.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port squash  input  1  flush all buffered instructions (branch mispredict / exception).
REQ-006 SHALL have port in_packet  input  IF_ID_PACKET[`N]  fetch group from fetch; valid lanes contiguous from lane 0.
REQ-007 SHALL have port dequeue_num  input  $clog2(`N+1)  instructions decode/dispatch can take this cycle, 0..`N.
REQ-008 SHALL have port ready  output  1  fetch may present a group this cycle.
REQ-009 SHALL have port out_packet  output  IF_ID_PACKET[`N]  oldest buffered instructions, lane 0 = oldest; feeds stage_decode.
REQ-010 SHALL have port count  output  $clog2(SIZE+1)  instructions currently held.

Function
REQ-011 SHALL store entries in a circular array of SIZE IF_ID_PACKETs with head and tail pointers of $clog2(SIZE) bits, wrapping modulo SIZE.
REQ-012 SHALL drive ready = (SIZE - count >= `N), from registered state only; same-cycle dequeues do not raise it.
REQ-013 SHALL compute enq_num = number of valid lanes of in_packet when ready=1 and squash=0; else enq_num = 0 (input ignored).
REQ-014 SHALL compute deq_num = min(dequeue_num, count) when squash=0; else 0.
REQ-015 SHALL drive out_packet[i] = entry[(head+i) mod SIZE] with valid = (i < count) and squash=0; all fields other than valid are don't-care when valid=0.
REQ-016 SHALL write in_packet[i] into entry[(tail+i) mod SIZE] for i < enq_num at the clock edge, unmodified (inst, PC, NPC, predict_taken, predict_target).
REQ-017 SHALL update at the edge: head += deq_num, tail += enq_num, count += enq_num - deq_num.
REQ-018 SHALL accept enqueue and dequeue in the same cycle, including when count=0 (dequeue yields 0) and when count=SIZE-`N (enqueue allowed, ready=1).
REQ-019 SHALL have minimum latency of one cycle: a group enqueued at edge k is first visible on out_packet after edge k; there is no combinational in-to-out bypass.
REQ-020 SHALL preserve program order: out_packet lanes and successive cycles present instructions strictly in enqueue order, across pointer wrap-around.
REQ-021 SHALL on squash=1 at an edge set head=0, tail=0, count=0; that cycle's in_packet is discarded and out_packet valid bits are all 0.
REQ-022 SHALL treat a non-contiguous in_packet valid pattern as a protocol violation; behaviour undefined, flagged by a bench assertion.
REQ-023 SHALL never let count exceed SIZE or go below 0; bench asserts this every cycle.

Reset
REQ-024 SHALL on reset=0 asynchronously force head=0, tail=0, count=0, all entry valid bits 0, regardless of clock.
REQ-025 SHALL while in reset drive out_packet valid bits all 0, count=0, ready=1.
REQ-026 SHALL resume normal operation on the first rising clock edge after reset deasserts; a reset asserted mid-operation discards all contents.

Verification (N=3, SIZE=8)
REQ-027 SHALL cover: reset, enqueue 3 valid (PC 0,4,8), dequeue_num=0 -> next cycle count=3, out_packet lanes 0..2 valid with PC 0,4,8.
REQ-028 SHALL cover: fill to count=6, dequeue_num=0 -> ready=0; further 3-valid group ignored, count stays 6; dequeue_num=3 -> count=3, ready=1 next cycle.
REQ-029 SHALL cover: count=2, enqueue 3, dequeue_num=3 same cycle -> deq_num=2, count=3 next cycle, order preserved.
REQ-030 SHALL cover: 20 cycles of enqueue 3 / dequeue 3 with incrementing PCs -> pointers wrap, out_packet PCs strictly sequential, no loss or duplicate.
REQ-031 SHALL cover: count=5, squash=1 with 3 valid inputs -> same cycle out valid 0; next cycle count=0, outputs invalid, ready=1.
REQ-032 SHALL cover: reset asserted asynchronously mid-cycle at count=4 -> count=0 and out valid 0 immediately, before the next clock edge.
